immediate_select: RTL and testbench
===================================

# immediate_select

Immediate generator for the RV32IM pipeline's decode stage. It takes the fetched 32-bit instruction and a 4-bit format select from the control unit, and produces the 32-bit immediate for the ALU/branch path. `OUTPUT` is purely combinational. `OUTPUT_Q` is a registered copy of it, captured into the ID/EX boundary register.

## Interface
- No parameters.
- `CLK` input 1: pipeline clock; `OUTPUT_Q` updates on the rising edge.
- `RESET` input 1: asynchronous, active-low reset. `RESET=0` clears `OUTPUT_Q` immediately.
- `INSTRUCTION` input 32: raw RV32 instruction word.
- `SELECT` input 4: format select.
  - `SELECT[2:0]` is the format.
  - `SELECT[3]` is the extension mode: 0 = sign-extend, 1 = zero-extend.
- `OUTPUT` output 32: combinational immediate.
- `OUTPUT_Q` output 32: `OUTPUT` registered on the rising edge of `CLK`.

## Operation
- Formats (`SELECT[2:0]`); `i` denotes `INSTRUCTION`:
  - `000` U: `{i[31:12], 12'b0}`. `SELECT[3]` is ignored.
  - `001` J: 21-bit `{i[31], i[19:12], i[20], i[30:21], 1'b0}`, extended to 32 bits.
  - `010` S: 12-bit `{i[31:25], i[11:7]}`, extended.
  - `011` B: 13-bit `{i[31], i[7], i[30:25], i[11:8], 1'b0}`, extended.
  - `100` I: 12-bit `i[31:20]`, extended.
  - `101` shift: `{27'b0, i[24:20]}`.
    - Always zero-extended; `SELECT[3]` is ignored.
    - `i[30]` (the SRAI/SRLI distinguisher) is never part of the shift immediate.
  - `110`, `111`: output `32'h0000_0000` for either value of `SELECT[3]`.
- Extension:
  - `SELECT[3]=0`: upper bits replicate the field MSB (`i[31]` for J/S/B/I).
  - `SELECT[3]=1`: upper bits are 0.
- Bits 0 of J and B immediates are always 0.
- No state other than the `OUTPUT_Q` register. No opcode decoding inside the block; `SELECT` alone chooses the format.
- X/undefined `SELECT` bits: no requirement beyond the legal encodings.

## Timing
- `OUTPUT` is combinational from `INSTRUCTION`/`SELECT`, with zero-cycle latency. It must be valid within the same time step (a bench samples 2 time units after the inputs change, with no clock edge).
- `OUTPUT_Q`:
  - Captures `OUTPUT` on every rising `CLK` edge while `RESET=1`; latency is 1 cycle.
  - No enable/stall input; it loads every cycle.
- Reset:
  - `RESET=0` forces `OUTPUT_Q=32'h0` asynchronously, independent of `CLK`.
  - `OUTPUT_Q` stays 0 while `RESET` is low.
  - The first rising edge after `RESET` returns high loads the current `OUTPUT`.
- `RESET` has no effect on `OUTPUT`. `OUTPUT` remains valid during reset, including when `CLK` is not toggling.
- Reset asserted mid-operation: `OUTPUT_Q` clears immediately and discards the captured value.

## Test plan
- **U/I:**
  - `INSTRUCTION=32'h123450B7`, `SELECT=0000` -> `OUTPUT=32'h12345000`; `SELECT=1000` -> same value.
  - `INSTRUCTION=32'hFFF00093`, `SELECT=0100` -> `32'hFFFFFFFF`; `SELECT=1100` -> `32'h00000FFF`.
- **S/B:**
  - `INSTRUCTION=32'hFE112E23` (sw imm -4), `SELECT=0010` -> `32'hFFFFFFFC`; `SELECT=1010` -> `32'h00000FFC`.
  - `INSTRUCTION=32'hFE000CE3` (beq -8), `SELECT=0011` -> `32'hFFFFFFF8`; `SELECT=1011` -> `32'h00001FF8`.
- **J/shift:**
  - `INSTRUCTION=32'h001000EF`, `SELECT=0001` -> `32'h00000800`.
  - `INSTRUCTION=32'h41F0D093` (srai 31), `SELECT=0101` -> `32'h0000001F`; same with `SELECT=1101`.
- **Unused selects:** `INSTRUCTION=32'hFFFFFFFF`, `SELECT=0110`, `0111`, `1110`, `1111` -> `OUTPUT=32'h0` in each case.
- **Register and reset:**
  - Hold `RESET=0`: `OUTPUT_Q=0` while `OUTPUT` tracks the inputs.
  - Release `RESET` and apply `32'hFFF00093`/`0100`: `OUTPUT_Q=32'hFFFFFFFF` after the first rising edge.
  - Drop `RESET` between edges: `OUTPUT_Q` goes to 0 immediately, without waiting for a `CLK` edge.
- **Randomized sweep:** random instructions across all 16 `SELECT` values. Compare `OUTPUT` against the format equations above, and check `OUTPUT_Q` equals the previous cycle's `OUTPUT`.

Source files
------------

// File: rtl/immediate_select.sv
// Immediate generator for the RV32IM decode stage.
// Produces the U/J/S/B/I/shift immediate combinationally from the raw
// instruction and a format select, and registers it into the ID/EX boundary.
module immediate_select (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic [3:0]  SELECT,
    output logic [31:0] OUTPUT,
    output logic [31:0] OUTPUT_Q
);

    localparam logic [2:0] FMT_U     = 3'b000;
    localparam logic [2:0] FMT_J     = 3'b001;
    localparam logic [2:0] FMT_S     = 3'b010;
    localparam logic [2:0] FMT_B     = 3'b011;
    localparam logic [2:0] FMT_I     = 3'b100;
    localparam logic [2:0] FMT_SHIFT = 3'b101;

    // Valid-bit masks for each extendable field width.
    localparam logic [31:0] MASK_J = 32'h001F_FFFF;
    localparam logic [31:0] MASK_B = 32'h0000_1FFF;
    localparam logic [31:0] MASK_12 = 32'h0000_0FFF;

    // Extends a right-aligned field: zero-extension keeps the field as is,
    // sign-extension fills every bit outside the mask with the field MSB.
    function automatic logic [31:0] extend_field(
        input logic [31:0] field,
        input logic [31:0] mask,
        input logic        sign,
        input logic        zext
    );
        logic [31:0] fill;
        fill = (zext) ? 32'h0 : ({32{sign}} & ~mask);
        return (field & mask) | fill;
    endfunction

    logic        zext;
    logic [31:0] imm_d;
    logic [31:0] imm_q;

    assign zext = SELECT[3];

    // Format decode: reassemble the scattered immediate bits and extend.
    always_comb begin
        imm_d = 32'h0;
        case (SELECT[2:0])
            FMT_U:     imm_d = {INSTRUCTION[31:12], 12'b0};
            FMT_J:     imm_d = extend_field({11'b0, INSTRUCTION[31], INSTRUCTION[19:12],
                                             INSTRUCTION[20], INSTRUCTION[30:21], 1'b0},
                                            MASK_J, INSTRUCTION[31], zext);
            FMT_S:     imm_d = extend_field({20'b0, INSTRUCTION[31:25], INSTRUCTION[11:7]},
                                            MASK_12, INSTRUCTION[31], zext);
            FMT_B:     imm_d = extend_field({19'b0, INSTRUCTION[31], INSTRUCTION[7],
                                             INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0},
                                            MASK_B, INSTRUCTION[31], zext);
            FMT_I:     imm_d = extend_field({20'b0, INSTRUCTION[31:20]},
                                            MASK_12, INSTRUCTION[31], zext);
            // Shift amount only; bit 30 (SRAI/SRLI) stays out of the immediate.
            FMT_SHIFT: imm_d = {27'b0, INSTRUCTION[24:20]};
            default:   imm_d = 32'h0;
        endcase
    end

    // ID/EX boundary register: loads every cycle, cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            imm_q <= 32'h0;
        end else begin
            imm_q <= imm_d;
        end
    end

    assign OUTPUT   = imm_d;
    assign OUTPUT_Q = imm_q;

endmodule

// File: tb/tb_immediate_select.sv
// Directed and randomized bench for immediate_select.
module tb_immediate_select;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [3:0]  SELECT;
    logic [31:0] OUTPUT;
    logic [31:0] OUTPUT_Q;
    logic        clk_en;

    int checks;
    int errors;

    immediate_select dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .SELECT      (SELECT),
        .OUTPUT      (OUTPUT),
        .OUTPUT_Q    (OUTPUT_Q)
    );

    initial CLK = 1'b0;
    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    // Reference immediate built straight from the format equations.
    function automatic logic [31:0] model(input logic [31:0] i, input logic [3:0] s);
        logic [20:0] j;
        logic [11:0] f12;
        logic [12:0] b;
        case (s[2:0])
            3'b000: return {i[31:12], 12'b0};
            3'b001: begin
                j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
                return s[3] ? {11'b0, j} : {{11{j[20]}}, j};
            end
            3'b010: begin
                f12 = {i[31:25], i[11:7]};
                return s[3] ? {20'b0, f12} : {{20{f12[11]}}, f12};
            end
            3'b011: begin
                b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
                return s[3] ? {19'b0, b} : {{19{b[12]}}, b};
            end
            3'b100: begin
                f12 = i[31:20];
                return s[3] ? {20'b0, f12} : {{20{f12[11]}}, f12};
            end
            3'b101: return {27'b0, i[24:20]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic apply_comb(input logic [31:0] instr, input logic [3:0] sel,
                              input logic [31:0] exp, input string name);
        INSTRUCTION = instr;
        SELECT      = sel;
        #2;
        checks++;
        if (OUTPUT !== exp) begin
            errors++;
            $display("FAIL %s: OUTPUT=%h expected %h", name, OUTPUT, exp);
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b0;
        RESET  = 1'b0;
        INSTRUCTION = 32'h123450B7;
        SELECT = 4'b0000;
        #2;
        checks++;
        if (OUTPUT_Q !== 32'h0) begin
            errors++;
            $display("FAIL reset_q: OUTPUT_Q=%h expected 00000000", OUTPUT_Q);
        end
        // OUTPUT must be valid in reset with no clock running.
        apply_comb(32'hFFF00093, 4'b0100, 32'hFFFFFFFF, "reset_comb_noclk");
        clk_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (OUTPUT_Q !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold_q: OUTPUT_Q=%h expected 00000000", OUTPUT_Q);
        end
        apply_comb(32'hFE112E23, 4'b0010, 32'hFFFFFFFC, "reset_comb_track");
    endtask

    task automatic test_u_i();
        apply_comb(32'h123450B7, 4'b0000, 32'h12345000, "u_sext");
        apply_comb(32'h123450B7, 4'b1000, 32'h12345000, "u_zext");
        apply_comb(32'hFFF00093, 4'b0100, 32'hFFFFFFFF, "i_sext");
        apply_comb(32'hFFF00093, 4'b1100, 32'h00000FFF, "i_zext");
    endtask

    task automatic test_s_b();
        apply_comb(32'hFE112E23, 4'b0010, 32'hFFFFFFFC, "s_sext");
        apply_comb(32'hFE112E23, 4'b1010, 32'h00000FFC, "s_zext");
        apply_comb(32'hFE000CE3, 4'b0011, 32'hFFFFFFF8, "b_sext");
        apply_comb(32'hFE000CE3, 4'b1011, 32'h00001FF8, "b_zext");
    endtask

    task automatic test_j_shift();
        apply_comb(32'h001000EF, 4'b0001, 32'h00000800, "j_bit11");
        apply_comb(32'hFFFFFFFF, 4'b0001, 32'hFFFFFFFE, "j_sext_ones");
        apply_comb(32'hFFFFFFFF, 4'b1001, 32'h001FFFFE, "j_zext_ones");
        apply_comb(32'hFFFFFFFF, 4'b1011, 32'h00001FFE, "b_zext_ones");
        apply_comb(32'h41F0D093, 4'b0101, 32'h0000001F, "shift_sext");
        apply_comb(32'h41F0D093, 4'b1101, 32'h0000001F, "shift_zext");
    endtask

    task automatic test_unused();
        apply_comb(32'hFFFFFFFF, 4'b0110, 32'h0, "unused_0110");
        apply_comb(32'hFFFFFFFF, 4'b0111, 32'h0, "unused_0111");
        apply_comb(32'hFFFFFFFF, 4'b1110, 32'h0, "unused_1110");
        apply_comb(32'hFFFFFFFF, 4'b1111, 32'h0, "unused_1111");
    endtask

    task automatic test_register_reset();
        @(negedge CLK);
        INSTRUCTION = 32'hFFF00093;
        SELECT = 4'b0100;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (OUTPUT_Q !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL release_load: OUTPUT_Q=%h expected ffffffff", OUTPUT_Q);
        end
        // Drop reset between edges; the clear must not wait for CLK.
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if (OUTPUT_Q !== 32'h0) begin
            errors++;
            $display("FAIL async_clear: OUTPUT_Q=%h expected 00000000", OUTPUT_Q);
        end
        checks++;
        if (OUTPUT !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL comb_in_reset: OUTPUT=%h expected ffffffff", OUTPUT);
        end
        @(negedge CLK);
        RESET = 1'b1;
        INSTRUCTION = 32'h123450B7;
        SELECT = 4'b0000;
        @(posedge CLK);
        #1;
        checks++;
        if (OUTPUT_Q !== 32'h12345000) begin
            errors++;
            $display("FAIL rerelease_load: OUTPUT_Q=%h expected 12345000", OUTPUT_Q);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] exp_q;
        for (int n = 0; n < 256; n++) begin
            @(negedge CLK);
            INSTRUCTION = $urandom;
            SELECT = 4'(n % 16);
            #2;
            exp = model(INSTRUCTION, SELECT);
            checks++;
            if (OUTPUT !== exp) begin
                errors++;
                $display("FAIL rand_comb: instr=%h sel=%b OUTPUT=%h expected %h",
                         INSTRUCTION, SELECT, OUTPUT, exp);
            end
            exp_q = exp;
            @(posedge CLK);
            #1;
            checks++;
            if (OUTPUT_Q !== exp_q) begin
                errors++;
                $display("FAIL rand_q: sel=%b OUTPUT_Q=%h expected %h", SELECT, OUTPUT_Q, exp_q);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_u_i();
        test_s_b();
        test_j_shift();
        test_unused();
        test_register_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
